// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: round-robin sharing of the NPC memory port
// between IFU and LSU, one transaction in flight, with a watchdog.
module npc_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                io_ifu_req_valid,
   output logic                io_ifu_req_ready,
   input  logic [ADDR_W-1:0]   io_ifu_req_addr,
   output logic                io_ifu_resp_valid,
   output logic [DATA_W-1:0]   io_ifu_resp_data,
   output logic                io_ifu_resp_err,
   input  logic                io_lsu_req_valid,
   output logic                io_lsu_req_ready,
   input  logic [ADDR_W-1:0]   io_lsu_req_addr,
   input  logic                io_lsu_req_wen,
   input  logic [DATA_W-1:0]   io_lsu_req_wdata,
   input  logic [DATA_W/8-1:0] io_lsu_req_wmask,
   output logic                io_lsu_resp_valid,
   output logic [DATA_W-1:0]   io_lsu_resp_data,
   output logic                io_lsu_resp_err,
   output logic                io_mem_req_valid,
   input  logic                io_mem_req_ready,
   output logic [ADDR_W-1:0]   io_mem_addr,
   output logic                io_mem_wen,
   output logic [DATA_W-1:0]   io_mem_wdata,
   output logic [DATA_W/8-1:0] io_mem_wmask,
   input  logic                io_mem_resp_valid,
   input  logic [DATA_W-1:0]   io_mem_resp_data,
   output logic                io_spurious
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] C_LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] C_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_last_lsu;
   logic                  r_own_lsu;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_wen;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wmask;
   logic [CW-1:0]         r_cnt;
   logic                  r_ifu_resp_valid;
   logic [DATA_W-1:0]     r_ifu_resp_data;
   logic                  r_ifu_resp_err;
   logic                  r_lsu_resp_valid;
   logic [DATA_W-1:0]     r_lsu_resp_data;
   logic                  r_lsu_resp_err;
   logic                  r_spurious;
   logic                  w_ifu_win;
   logic                  w_lsu_win;
   logic                  w_mem_req_valid;
   logic                  w_tout;
   logic                  w_done;

   // a real response in the same cycle pre-empts the watchdog
   assign w_tout = (TIMEOUT > 0) && (r_state == S_WAIT)
                   && !io_mem_resp_valid && (r_cnt == C_LIM);
   assign w_done = (r_state == S_WAIT) && (io_mem_resp_valid || w_tout);

   // state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next state, grant and memory request strobe
   always_comb begin
      w_next          = r_state;
      w_ifu_win       = 1'b0;
      w_lsu_win       = 1'b0;
      w_mem_req_valid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_ifu_win = io_ifu_req_valid && (!io_lsu_req_valid || r_last_lsu);
            w_lsu_win = io_lsu_req_valid && (!io_ifu_req_valid || !r_last_lsu);
            if (w_ifu_win || w_lsu_win) w_next = S_REQ;
         end
         S_REQ: begin
            w_mem_req_valid = 1'b1;
            if (io_mem_req_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_done) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // capture the winning request; fetches never write
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_lsu <= 1'b1;
         r_own_lsu  <= 1'b0;
         r_addr     <= '0;
         r_wen      <= 1'b0;
         r_wdata    <= '0;
         r_wmask    <= '0;
      end else if (w_ifu_win) begin
         r_last_lsu <= 1'b0;
         r_own_lsu  <= 1'b0;
         r_addr     <= io_ifu_req_addr;
         r_wen      <= 1'b0;
         r_wdata    <= '0;
         r_wmask    <= '0;
      end else if (w_lsu_win) begin
         r_last_lsu <= 1'b1;
         r_own_lsu  <= 1'b1;
         r_addr     <= io_lsu_req_addr;
         r_wen      <= io_lsu_req_wen;
         r_wdata    <= io_lsu_req_wdata;
         r_wmask    <= io_lsu_req_wmask;
      end
   end

   // watchdog: cleared at the handshake, saturating count in WAIT
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == S_REQ && io_mem_req_ready) begin
         r_cnt <= '0;
      end else if (r_state == S_WAIT && r_cnt != C_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // route the response (or watchdog error) to the owner as a pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ifu_resp_valid <= 1'b0;
         r_ifu_resp_data  <= '0;
         r_ifu_resp_err   <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_lsu_resp_data  <= '0;
         r_lsu_resp_err   <= 1'b0;
      end else begin
         r_ifu_resp_valid <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         if (w_done && r_own_lsu) begin
            r_lsu_resp_valid <= 1'b1;
            r_lsu_resp_data  <= io_mem_resp_valid ? io_mem_resp_data : '0;
            r_lsu_resp_err   <= !io_mem_resp_valid;
         end else if (w_done) begin
            r_ifu_resp_valid <= 1'b1;
            r_ifu_resp_data  <= io_mem_resp_valid ? io_mem_resp_data : '0;
            r_ifu_resp_err   <= !io_mem_resp_valid;
         end
      end
   end

   // sticky flag for memory responses nobody asked for
   always_ff @(posedge clock) begin
      if (reset) begin
         r_spurious <= 1'b0;
      end else if (io_mem_resp_valid && r_state != S_WAIT) begin
         r_spurious <= 1'b1;
      end
   end

   assign io_ifu_req_ready  = w_ifu_win;
   assign io_lsu_req_ready  = w_lsu_win;
   assign io_mem_req_valid  = w_mem_req_valid;
   assign io_mem_addr       = r_addr;
   assign io_mem_wen        = r_wen;
   assign io_mem_wdata      = r_wdata;
   assign io_mem_wmask      = r_wmask;
   assign io_ifu_resp_valid = r_ifu_resp_valid;
   assign io_ifu_resp_data  = r_ifu_resp_data;
   assign io_ifu_resp_err   = r_ifu_resp_err;
   assign io_lsu_resp_valid = r_lsu_resp_valid;
   assign io_lsu_resp_data  = r_lsu_resp_data;
   assign io_lsu_resp_err   = r_lsu_resp_err;
   assign io_spurious       = r_spurious;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// tb_npc_mem_arbiter: vector table plus response scoreboard
// for the IFU/LSU memory arbiter (TIMEOUT = 8).
module tb_npc_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_ifu_req_valid;
   logic        io_ifu_req_ready;
   logic [31:0] io_ifu_req_addr;
   logic        io_ifu_resp_valid;
   logic [31:0] io_ifu_resp_data;
   logic        io_ifu_resp_err;
   logic        io_lsu_req_valid;
   logic        io_lsu_req_ready;
   logic [31:0] io_lsu_req_addr;
   logic        io_lsu_req_wen;
   logic [31:0] io_lsu_req_wdata;
   logic [3:0]  io_lsu_req_wmask;
   logic        io_lsu_resp_valid;
   logic [31:0] io_lsu_resp_data;
   logic        io_lsu_resp_err;
   logic        io_mem_req_valid;
   logic        io_mem_req_ready;
   logic [31:0] io_mem_addr;
   logic        io_mem_wen;
   logic [31:0] io_mem_wdata;
   logic [3:0]  io_mem_wmask;
   logic        io_mem_resp_valid;
   logic [31:0] io_mem_resp_data;
   logic        io_spurious;

   npc_mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (8)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .io_ifu_req_valid  (io_ifu_req_valid),
      .io_ifu_req_ready  (io_ifu_req_ready),
      .io_ifu_req_addr   (io_ifu_req_addr),
      .io_ifu_resp_valid (io_ifu_resp_valid),
      .io_ifu_resp_data  (io_ifu_resp_data),
      .io_ifu_resp_err   (io_ifu_resp_err),
      .io_lsu_req_valid  (io_lsu_req_valid),
      .io_lsu_req_ready  (io_lsu_req_ready),
      .io_lsu_req_addr   (io_lsu_req_addr),
      .io_lsu_req_wen    (io_lsu_req_wen),
      .io_lsu_req_wdata  (io_lsu_req_wdata),
      .io_lsu_req_wmask  (io_lsu_req_wmask),
      .io_lsu_resp_valid (io_lsu_resp_valid),
      .io_lsu_resp_data  (io_lsu_resp_data),
      .io_lsu_resp_err   (io_lsu_resp_err),
      .io_mem_req_valid  (io_mem_req_valid),
      .io_mem_req_ready  (io_mem_req_ready),
      .io_mem_addr       (io_mem_addr),
      .io_mem_wen        (io_mem_wen),
      .io_mem_wdata      (io_mem_wdata),
      .io_mem_wmask      (io_mem_wmask),
      .io_mem_resp_valid (io_mem_resp_valid),
      .io_mem_resp_data  (io_mem_resp_data),
      .io_spurious       (io_spurious)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          lsu;
      logic [31:0] addr;
      bit          wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          rdy_dly;
      int          resp_dly;
      bit          to;
      logic [31:0] rdata;
      bit          e_wen;
      logic [31:0] e_wdata;
      logic [3:0]  e_wmask;
      logic [31:0] e_data;
      bit          e_err;
   } vec_t;

   typedef struct {
      bit          lsu;
      logic [31:0] data;
      bit          err;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[8];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_resp  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock; any response pulse is popped from the scoreboard
   task automatic cyc();
      exp_t        e;
      logic [31:0] d;
      logic        er;
      @(posedge clock);
      #1;
      if (io_ifu_resp_valid || io_lsu_resp_valid) begin
         n_resp++;
         chk("resp_both", 32'(io_ifu_resp_valid & io_lsu_resp_valid), 32'd0);
         if (sb.size() == 0) begin
            chk("resp_unexpected", 32'(n_resp), 32'(n_resp - 1));
         end else begin
            e  = sb.pop_front();
            d  = io_lsu_resp_valid ? io_lsu_resp_data : io_ifu_resp_data;
            er = io_lsu_resp_valid ? io_lsu_resp_err : io_ifu_resp_err;
            chk("resp_owner", 32'(io_lsu_resp_valid), 32'(e.lsu));
            chk("resp_data", d, e.data);
            chk("resp_err", 32'(er), 32'(e.err));
         end
      end
   endtask

   task automatic idle_inputs();
      io_ifu_req_valid  = 1'b0;
      io_ifu_req_addr   = '0;
      io_lsu_req_valid  = 1'b0;
      io_lsu_req_addr   = '0;
      io_lsu_req_wen    = 1'b0;
      io_lsu_req_wdata  = '0;
      io_lsu_req_wmask  = '0;
      io_mem_req_ready  = 1'b0;
      io_mem_resp_valid = 1'b0;
      io_mem_resp_data  = '0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n0;
      int k;
      io_ifu_req_valid = !v.lsu;
      io_ifu_req_addr  = v.addr;
      io_lsu_req_valid = v.lsu;
      io_lsu_req_addr  = v.addr;
      io_lsu_req_wen   = v.wen;
      io_lsu_req_wdata = v.wdata;
      io_lsu_req_wmask = v.wmask;
      #1;
      chk("ifu_ready", 32'(io_ifu_req_ready), 32'(!v.lsu));
      chk("lsu_ready", 32'(io_lsu_req_ready), 32'(v.lsu));
      cyc();
      io_ifu_req_valid = 1'b0;
      io_lsu_req_valid = 1'b0;
      io_ifu_req_addr  = ~v.addr;
      io_lsu_req_addr  = ~v.addr;
      io_lsu_req_wdata = ~v.wdata;
      io_lsu_req_wmask = ~v.wmask;
      io_lsu_req_wen   = !v.wen;
      for (k = 0; k <= v.rdy_dly; k++) begin
         io_mem_req_ready = (k == v.rdy_dly);
         #1;
         chk("req_valid", 32'(io_mem_req_valid), 32'd1);
         chk("mem_addr", io_mem_addr, v.addr);
         chk("mem_wen", 32'(io_mem_wen), 32'(v.e_wen));
         chk("mem_wdata", io_mem_wdata, v.e_wdata);
         chk("mem_wmask", 32'(io_mem_wmask), 32'(v.e_wmask));
         cyc();
      end
      io_mem_req_ready = 1'b0;
      #1;
      chk("wait_valid", 32'(io_mem_req_valid), 32'd0);
      n0 = n_resp;
      if (v.to) begin
         sb.push_back('{lsu: v.lsu, data: v.e_data, err: v.e_err});
         k = 0;
         while (n_resp == n0 && k < 20) begin
            cyc();
            k++;
         end
         chk("tout_lat", 32'(k), 32'd8);
      end else begin
         for (k = 0; k < v.resp_dly; k++) cyc();
         chk("early_resp", 32'(n_resp), 32'(n0));
         io_mem_resp_valid = 1'b1;
         io_mem_resp_data  = v.rdata;
         sb.push_back('{lsu: v.lsu, data: v.e_data, err: v.e_err});
         cyc();
         io_mem_resp_valid = 1'b0;
         io_mem_resp_data  = '0;
         chk("resp_seen", 32'(n_resp), 32'(n0 + 1));
      end
      cyc();
      chk("extra_resp", 32'(n_resp), 32'(n0 + 1));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("no_spurious", 32'(io_spurious), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int   n0;
      logic w;
      tbl[0] = '{1'b0, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0,
                 32'h0000_0413, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1'b0};
      tbl[1] = '{1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 5, 0, 1'b0,
                 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 1'b0};
      tbl[2] = '{1'b1, 32'h8000_2004, 1'b0, 32'h0, 4'hF, 1, 3, 1'b0,
                 32'hCAFE_F00D, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0};
      tbl[3] = '{1'b0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1,
                 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1};
      tbl[4] = '{1'b0, 32'h8000_0014, 1'b0, 32'h0, 4'h0, 0, 2, 1'b0,
                 32'h0010_0073, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 1'b0};
      tbl[5] = '{1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'hF, 2, 0, 1'b1,
                 32'h0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1};
      tbl[6] = '{1'b1, 32'h8000_3004, 1'b1, 32'h0BAD_F00D, 4'hC, 2, 1, 1'b0,
                 32'h5555_AAAA, 1'b1, 32'h0BAD_F00D, 4'hC, 32'h5555_AAAA, 1'b0};
      tbl[7] = '{1'b0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, 7, 1'b0,
                 32'h1111_2222, 1'b0, 32'h0, 4'h0, 32'h1111_2222, 1'b0};

      idle_inputs();
      reset_dut();
      #1;
      chk("rst_req_valid", 32'(io_mem_req_valid), 32'd0);
      chk("rst_addr", io_mem_addr, 32'd0);
      chk("rst_wen", 32'(io_mem_wen), 32'd0);
      chk("rst_wdata", io_mem_wdata, 32'd0);
      chk("rst_wmask", 32'(io_mem_wmask), 32'd0);
      chk("rst_ifu_resp", 32'(io_ifu_resp_valid), 32'd0);
      chk("rst_lsu_resp", 32'(io_lsu_resp_valid), 32'd0);
      chk("rst_spurious", 32'(io_spurious), 32'd0);
      chk("rst_ready", 32'({io_ifu_req_ready, io_lsu_req_ready}), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // round robin with both requesters held valid
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         w = i[0];
         io_ifu_req_valid = 1'b1;
         io_lsu_req_valid = 1'b1;
         io_ifu_req_addr  = 32'h1000 + 32'(i * 4);
         io_lsu_req_addr  = 32'h2000 + 32'(i * 4);
         io_lsu_req_wen   = 1'b0;
         #1;
         chk("rr_ifu_ready", 32'(io_ifu_req_ready), 32'(!w));
         chk("rr_lsu_ready", 32'(io_lsu_req_ready), 32'(w));
         cyc();
         #1;
         chk("rr_busy_ready",
             32'(io_ifu_req_ready | io_lsu_req_ready), 32'd0);
         chk("rr_addr", io_mem_addr,
             w ? 32'h2000 + 32'(i * 4) : 32'h1000 + 32'(i * 4));
         io_mem_req_ready = 1'b1;
         cyc();
         io_mem_req_ready  = 1'b0;
         io_mem_resp_valid = 1'b1;
         io_mem_resp_data  = 32'(i + 100);
         sb.push_back('{lsu: w, data: 32'(i + 100), err: 1'b0});
         cyc();
         io_mem_resp_valid = 1'b0;
      end
      io_ifu_req_valid = 1'b0;
      io_lsu_req_valid = 1'b0;
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);

      // stray response while idle
      idle_inputs();
      reset_dut();
      n0 = n_resp;
      io_mem_resp_valid = 1'b1;
      io_mem_resp_data  = 32'hBAD0_BAD0;
      cyc();
      io_mem_resp_valid = 1'b0;
      chk("spur_set", 32'(io_spurious), 32'd1);
      for (int i = 0; i < 4; i++) cyc();
      chk("spur_sticky", 32'(io_spurious), 32'd1);
      chk("spur_no_resp", 32'(n_resp), 32'(n0));
      reset_dut();
      #1;
      chk("spur_cleared", 32'(io_spurious), 32'd0);

      // reset during WAIT, then a late response
      io_ifu_req_valid = 1'b1;
      io_ifu_req_addr  = 32'h8000_0040;
      cyc();
      io_ifu_req_valid = 1'b0;
      io_mem_req_ready = 1'b1;
      cyc();
      io_mem_req_ready = 1'b0;
      cyc();
      n0 = n_resp;
      reset_dut();
      #1;
      chk("rw_req_valid", 32'(io_mem_req_valid), 32'd0);
      io_lsu_req_valid = 1'b1;
      #1;
      chk("rw_idle_ready", 32'(io_lsu_req_ready), 32'd1);
      io_lsu_req_valid = 1'b0;
      io_mem_resp_valid = 1'b1;
      io_mem_resp_data  = 32'h0000_0413;
      cyc();
      io_mem_resp_valid = 1'b0;
      for (int i = 0; i < 12; i++) cyc();
      chk("rw_no_resp", 32'(n_resp), 32'(n0));
      chk("rw_spurious", 32'(io_spurious), 32'd1);
      chk("rw_still_idle", 32'(io_mem_req_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
